// File: rtl/ts_pkt_arb_if.sv
// ts_pkt_arb_if: requester byte streams in, arbitrated transport-packet byte stream out.
interface ts_pkt_arb_if;
    logic [31:0] req_data;
    logic [3:0]  req_valid;
    logic [3:0]  req_sync;
    logic [3:0]  req_ready;
    logic        dout_ready;
    logic [7:0]  dout;
    logic        doutstb;
    logic        doutsync;
    logic [1:0]  grant;
    logic        busy;
    logic        abort;
    modport slave (
        input  req_data, req_valid, req_sync, dout_ready,
        output req_ready, dout, doutstb, doutsync, grant, busy, abort
    );
    modport master (
        output req_data, req_valid, req_sync, dout_ready,
        input  req_ready, dout, doutstb, doutsync, grant, busy, abort
    );
endinterface

// File: rtl/ts_pkt_arb.sv
// ts_pkt_arb: round-robin arbiter forwarding whole transport packets from four framed
// byte streams; a premature head truncates the packet and the remainder is padded.
module ts_pkt_arb #(
    parameter int         NPORT  = 4,
    parameter int         PKTLEN = 188,
    parameter logic [7:0] FILL   = 8'hFF
) (
    input logic        clk,
    input logic        reset,
    ts_pkt_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, XFER, PAD} state_t;
    state_t     state_q, state_d;
    logic [1:0] grant_q, grant_d, last_grant_q, last_grant_d, pick, idx;
    logic [7:0] bytecnt_q, bytecnt_d, dout_q, dout_d, gbyte;
    logic       doutstb_q, doutstb_d, doutsync_q, doutsync_d, abort_q, abort_d;
    logic       found, last;
    logic [3:0] heads, ready_c;
    always_comb begin
        heads = bus.req_valid & bus.req_sync;
        pick  = last_grant_q;
        idx   = last_grant_q;
        found = 1'b0;
        for (int k = 1; k <= NPORT; k++) begin
            idx = last_grant_q + 2'(k);
            if (!found && heads[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        gbyte        = bus.req_data[{grant_q, 3'b000} +: 8];
        last         = bytecnt_q == 8'(PKTLEN - 1);
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        bytecnt_d    = bytecnt_q;
        dout_d       = dout_q;
        doutstb_d    = 1'b0;
        doutsync_d   = 1'b0;
        abort_d      = 1'b0;
        ready_c      = 4'b0;
        case (state_q)
            IDLE: begin
                // non-head bytes are discarded while hunting for a packet start
                ready_c = bus.req_valid & ~bus.req_sync;
                if (found) begin
                    grant_d   = pick;
                    bytecnt_d = 8'd0;
                    state_d   = XFER;
                end
            end
            XFER: begin
                if (heads[grant_q] && bytecnt_q != 8'd0) begin
                    abort_d = 1'b1;
                    state_d = PAD;
                end else begin
                    ready_c[grant_q] = bus.dout_ready;
                    if (bus.req_valid[grant_q] && bus.dout_ready) begin
                        dout_d     = gbyte;
                        doutstb_d  = 1'b1;
                        doutsync_d = bytecnt_q == 8'd0;
                        bytecnt_d  = last ? 8'd0 : bytecnt_q + 8'd1;
                        if (last) begin
                            state_d      = IDLE;
                            last_grant_d = grant_q;
                        end
                    end
                end
            end
            PAD: begin
                if (bus.dout_ready) begin
                    dout_d    = FILL;
                    doutstb_d = 1'b1;
                    bytecnt_d = last ? 8'd0 : bytecnt_q + 8'd1;
                    if (last) begin
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 2'd0;
            last_grant_q <= 2'd3;
            bytecnt_q    <= 8'd0;
            dout_q       <= 8'd0;
            doutstb_q    <= 1'b0;
            doutsync_q   <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            bytecnt_q    <= bytecnt_d;
            dout_q       <= dout_d;
            doutstb_q    <= doutstb_d;
            doutsync_q   <= doutsync_d;
            abort_q      <= abort_d;
        end
    end
    // ready is combinational, so it is gated directly by the asynchronous reset
    assign bus.req_ready = reset ? 4'b0 : ready_c;
    assign bus.dout      = dout_q;
    assign bus.doutstb   = doutstb_q;
    assign bus.doutsync  = doutsync_q;
    assign bus.abort     = abort_q;
    assign bus.grant     = grant_q;
    assign bus.busy      = state_q != IDLE;
endmodule
